// File: rtl/chien_search.sv
// Chien search: evaluates the error-locator polynomial sigma(x) at alpha^k, k = 0..n-1,
// one point per clock, and reports each root as a codeword error position.
module chien_search #(
    parameter int unsigned T_MAX = 4,
    parameter int unsigned M_MAX = 10
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic [3:0]                 t,
    input  logic [3:0]                 m,
    input  logic [3:0]                 degree,
    input  logic [(T_MAX+1)*M_MAX-1:0] sigma,
    output logic                       busy,
    output logic                       loc_valid,
    output logic [M_MAX-1:0]           loc,
    output logic                       done,
    output logic [3:0]                 err_cnt,
    output logic                       failure
);

    localparam int unsigned NC = T_MAX + 1;

    typedef enum logic [1:0] {StIdle, StScan, StFin} state_e;

    state_e           state_q, state_d;
    logic [M_MAX-1:0] r_q [NC];
    logic [M_MAX-1:0] r_d [NC];
    logic [M_MAX-1:0] mask_q, mask_d;
    logic [M_MAX-1:0] k_q, k_d;
    logic [M_MAX-1:0] loc_q, loc_d;
    logic [3:0]       m_q, m_d;
    logic [3:0]       deg_q, deg_d;
    logic [3:0]       err_cnt_q, err_cnt_d;
    logic             bad_q, bad_d;
    logic             busy_q, busy_d;
    logic             loc_valid_q, loc_valid_d;
    logic             done_q, done_d;
    logic             failure_q, failure_d;
    logic [M_MAX-1:0] syn;
    logic             m_ok;

    // Low m bits set; doubles as n = 2^m - 1.
    function automatic logic [M_MAX-1:0] field_mask(input logic [3:0] mw);
        logic [M_MAX-1:0] r;
        for (int i = 0; i < M_MAX; i++) begin
            r[i] = (i < int'(mw));
        end
        return r;
    endfunction

    function automatic logic [M_MAX-1:0] xtime(input logic [M_MAX-1:0] a,
                                               input logic [3:0]       mw,
                                               input logic [M_MAX-1:0] mask);
        logic [M_MAX-1:0] p;
        logic             msb;
        case (mw)
            4'd6:    p = M_MAX'(8'h03);
            4'd8:    p = M_MAX'(8'h1d);
            4'd10:   p = M_MAX'(8'h09);
            default: p = '0;
        endcase
        msb = |(a & mask & ~(mask >> 1));
        return ((a << 1) & mask) ^ (msb ? p : '0);
    endfunction

    function automatic logic [M_MAX-1:0] mul_alpha_pow(input logic [M_MAX-1:0] a,
                                                       input int unsigned      j,
                                                       input logic [3:0]       mw,
                                                       input logic [M_MAX-1:0] mask);
        logic [M_MAX-1:0] v;
        v = a;
        for (int unsigned i = 0; i < T_MAX; i++) begin
            if (i < j) v = xtime(v, mw, mask);
        end
        return v;
    endfunction

    assign m_ok = (m == 4'd6) || (m == 4'd8) || (m == 4'd10);

    always_comb begin
        syn = '0;
        for (int unsigned j = 0; j < NC; j++) begin
            syn = syn ^ r_q[j];
        end
    end

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        mask_d      = mask_q;
        k_d         = k_q;
        loc_d       = loc_q;
        m_d         = m_q;
        deg_d       = deg_q;
        err_cnt_d   = err_cnt_q;
        bad_d       = bad_q;
        busy_d      = busy_q;
        loc_valid_d = 1'b0;
        done_d      = 1'b0;
        failure_d   = failure_q;

        unique case (state_q)
            StIdle: begin
                // The done cycle is still in IDLE; a start there must not be taken.
                if (start && !done_q) begin
                    mask_d    = field_mask(m);
                    m_d       = m;
                    deg_d     = degree;
                    err_cnt_d = 4'd0;
                    failure_d = 1'b0;
                    bad_d     = 1'b0;
                    if (!m_ok || (degree > t)) begin
                        bad_d   = 1'b1;
                        state_d = StFin;
                    end else if (degree == 4'd0) begin
                        state_d = StFin;
                    end else begin
                        for (int unsigned j = 0; j < NC; j++) begin
                            r_d[j] = sigma[j*M_MAX +: M_MAX] & field_mask(m);
                        end
                        k_d     = '0;
                        busy_d  = 1'b1;
                        state_d = StScan;
                    end
                end
            end
            StScan: begin
                if (syn == '0) begin
                    loc_valid_d = 1'b1;
                    loc_d       = (k_q == '0) ? '0 : mask_q - k_q;
                    if (err_cnt_q != 4'hf) err_cnt_d = err_cnt_q + 4'd1;
                end
                for (int unsigned j = 0; j < NC; j++) begin
                    r_d[j] = mul_alpha_pow(r_q[j], j, m_q, mask_q);
                end
                k_d = k_q + M_MAX'(1);
                if (k_q == mask_q - M_MAX'(1)) state_d = StFin;
            end
            StFin: begin
                done_d    = 1'b1;
                busy_d    = 1'b0;
                failure_d = bad_q | (err_cnt_q != deg_q);
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            for (int unsigned j = 0; j < NC; j++) r_q[j] <= '0;
            mask_q      <= '0;
            k_q         <= '0;
            loc_q       <= '0;
            m_q         <= '0;
            deg_q       <= '0;
            err_cnt_q   <= '0;
            bad_q       <= 1'b0;
            busy_q      <= 1'b0;
            loc_valid_q <= 1'b0;
            done_q      <= 1'b0;
            failure_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            mask_q      <= mask_d;
            k_q         <= k_d;
            loc_q       <= loc_d;
            m_q         <= m_d;
            deg_q       <= deg_d;
            err_cnt_q   <= err_cnt_d;
            bad_q       <= bad_d;
            busy_q      <= busy_d;
            loc_valid_q <= loc_valid_d;
            done_q      <= done_d;
            failure_q   <= failure_d;
        end
    end

    assign busy      = busy_q;
    assign loc_valid = loc_valid_q;
    assign loc       = loc_q;
    assign done      = done_q;
    assign err_cnt   = err_cnt_q;
    assign failure   = failure_q;

endmodule

// File: tb/tb_chien_search.sv
// Directed bench for chien_search: roots at known positions, early exits, ignored starts
// and mid-scan reset, with edge-accurate timing checks.
module tb_chien_search;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [3:0]  t;
    logic [3:0]  m;
    logic [3:0]  degree;
    logic [49:0] sigma;
    logic        busy;
    logic        loc_valid;
    logic [9:0]  loc;
    logic        done;
    logic [3:0]  err_cnt;
    logic        failure;

    int n_cmp = 0;
    int n_bad = 0;

    int         ev_edge[$];
    logic [9:0] ev_loc[$];
    int         done_edge;
    logic [3:0] res_cnt;
    logic       res_fail;
    logic       res_busy;
    logic       overlap;

    chien_search #(.T_MAX(4), .M_MAX(10)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .t         (t),
        .m         (m),
        .degree    (degree),
        .sigma     (sigma),
        .busy      (busy),
        .loc_valid (loc_valid),
        .loc       (loc),
        .done      (done),
        .err_cnt   (err_cnt),
        .failure   (failure)
    );

    always #5 clk = ~clk;

    function automatic logic [49:0] pack(input logic [9:0] s0, input logic [9:0] s1,
                                         input logic [9:0] s2);
        return {20'd0, s2, s1, s0};
    endfunction

    // alpha^e in GF(2^10) with x^10 + x^3 + 1 (0x409).
    function automatic logic [9:0] pow10(input int e);
        int v;
        v = 1;
        for (int i = 0; i < e; i++) begin
            v = v << 1;
            if ((v & 'h400) != 0) v = v ^ 'h409;
        end
        return v[9:0];
    endfunction

    // Leaves one idle cycle first so a preceding done cycle cannot swallow the pulse.
    task automatic do_start(input logic [3:0] mm, input logic [3:0] tt, input logic [3:0] dd,
                            input logic [49:0] sg);
        @(posedge clk);
        @(negedge clk);
        m = mm; t = tt; degree = dd; sigma = sg; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int first_edge, input int last_edge);
        ev_edge.delete();
        ev_loc.delete();
        done_edge = -1;
        overlap   = 1'b0;
        for (int e = first_edge; e <= last_edge; e++) begin
            @(posedge clk);
            #1;
            if (loc_valid) begin
                ev_edge.push_back(e);
                ev_loc.push_back(loc);
            end
            if (loc_valid && done) overlap = 1'b1;
            if (done) begin
                done_edge = e;
                res_cnt   = err_cnt;
                res_fail  = failure;
                res_busy  = busy;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0; start = 1'b0; t = '0; m = '0; degree = '0; sigma = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (loc_valid !== 1'b0) begin n_bad++; $display("FAIL reset_lv got %b want 0", loc_valid); end
        n_cmp++; if (loc !== 10'd0) begin n_bad++; $display("FAIL reset_loc got %0d want 0", loc); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (err_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", err_cnt); end
        n_cmp++; if (failure !== 1'b0) begin n_bad++; $display("FAIL reset_fail got %b want 0", failure); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_m6_single;
        do_start(4'd6, 4'd2, 4'd1, pack(10'd1, 10'd1, 10'd0));
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL m6_busy got %b want 1", busy); end
        wait_done(1, 100);
        n_cmp++;
        if (ev_edge.size() != 1) begin
            n_bad++; $display("FAIL m6_nloc got %0d want 1", ev_edge.size());
        end else begin
            n_cmp++; if (ev_edge[0] != 1) begin n_bad++; $display("FAIL m6_edge got %0d want 1", ev_edge[0]); end
            n_cmp++; if (ev_loc[0] !== 10'd0) begin n_bad++; $display("FAIL m6_loc got %0d want 0", ev_loc[0]); end
        end
        n_cmp++; if (done_edge != 64) begin n_bad++; $display("FAIL m6_done got %0d want 64", done_edge); end
        n_cmp++; if (res_cnt !== 4'd1) begin n_bad++; $display("FAIL m6_cnt got %0d want 1", res_cnt); end
        n_cmp++; if (res_fail !== 1'b0) begin n_bad++; $display("FAIL m6_fail got %b want 0", res_fail); end
        n_cmp++; if (res_busy !== 1'b0) begin n_bad++; $display("FAIL m6_busy_done got %b want 0", res_busy); end
        n_cmp++; if (overlap !== 1'b0) begin n_bad++; $display("FAIL m6_overlap got %b want 0", overlap); end
    endtask

    task automatic test_m8_single;
        // alpha^5 = x^5 = 0x20 in GF(2^8); root at k = 255 - 5 = 250.
        do_start(4'd8, 4'd4, 4'd1, pack(10'd1, 10'h020, 10'd0));
        wait_done(1, 300);
        n_cmp++;
        if (ev_edge.size() != 1) begin
            n_bad++; $display("FAIL m8_nloc got %0d want 1", ev_edge.size());
        end else begin
            n_cmp++; if (ev_edge[0] != 251) begin n_bad++; $display("FAIL m8_edge got %0d want 251", ev_edge[0]); end
            n_cmp++; if (ev_loc[0] !== 10'd5) begin n_bad++; $display("FAIL m8_loc got %0d want 5", ev_loc[0]); end
        end
        n_cmp++; if (done_edge != 256) begin n_bad++; $display("FAIL m8_done got %0d want 256", done_edge); end
        n_cmp++; if (res_cnt !== 4'd1) begin n_bad++; $display("FAIL m8_cnt got %0d want 1", res_cnt); end
        n_cmp++; if (res_fail !== 1'b0) begin n_bad++; $display("FAIL m8_fail got %b want 0", res_fail); end
    endtask

    task automatic test_m10_double;
        logic [9:0] s1, s2;
        s1 = pow10(3) ^ pow10(100);
        s2 = pow10(103);
        do_start(4'd10, 4'd4, 4'd2, pack(10'd1, s1, s2));
        wait_done(1, 1100);
        n_cmp++;
        if (ev_edge.size() != 2) begin
            n_bad++; $display("FAIL m10_nloc got %0d want 2", ev_edge.size());
        end else begin
            n_cmp++; if (ev_edge[0] != 924) begin n_bad++; $display("FAIL m10_edge0 got %0d want 924", ev_edge[0]); end
            n_cmp++; if (ev_loc[0] !== 10'd100) begin n_bad++; $display("FAIL m10_loc0 got %0d want 100", ev_loc[0]); end
            n_cmp++; if (ev_edge[1] != 1021) begin n_bad++; $display("FAIL m10_edge1 got %0d want 1021", ev_edge[1]); end
            n_cmp++; if (ev_loc[1] !== 10'd3) begin n_bad++; $display("FAIL m10_loc1 got %0d want 3", ev_loc[1]); end
        end
        n_cmp++; if (done_edge != 1024) begin n_bad++; $display("FAIL m10_done got %0d want 1024", done_edge); end
        n_cmp++; if (res_cnt !== 4'd2) begin n_bad++; $display("FAIL m10_cnt got %0d want 2", res_cnt); end
        n_cmp++; if (res_fail !== 1'b0) begin n_bad++; $display("FAIL m10_fail got %b want 0", res_fail); end
    endtask

    task automatic test_degree_mismatch;
        do_start(4'd6, 4'd2, 4'd2, pack(10'd1, 10'd1, 10'd0));
        wait_done(1, 100);
        n_cmp++; if (done_edge != 64) begin n_bad++; $display("FAIL mism_done got %0d want 64", done_edge); end
        n_cmp++; if (res_cnt !== 4'd1) begin n_bad++; $display("FAIL mism_cnt got %0d want 1", res_cnt); end
        n_cmp++; if (res_fail !== 1'b1) begin n_bad++; $display("FAIL mism_fail got %b want 1", res_fail); end
    endtask

    task automatic test_early_exits;
        // degree 0: err_cnt from the previous run (1) must be cleared.
        do_start(4'd6, 4'd2, 4'd0, pack(10'd1, 10'd0, 10'd0));
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL deg0_busy got %b want 0", busy); end
        wait_done(1, 10);
        n_cmp++; if (done_edge != 1) begin n_bad++; $display("FAIL deg0_done got %0d want 1", done_edge); end
        n_cmp++; if (res_cnt !== 4'd0) begin n_bad++; $display("FAIL deg0_cnt got %0d want 0", res_cnt); end
        n_cmp++; if (res_fail !== 1'b0) begin n_bad++; $display("FAIL deg0_fail got %b want 0", res_fail); end

        do_start(4'd7, 4'd2, 4'd1, pack(10'd1, 10'd1, 10'd0));
        wait_done(1, 10);
        n_cmp++; if (done_edge != 1) begin n_bad++; $display("FAIL m7_done got %0d want 1", done_edge); end
        n_cmp++; if (res_cnt !== 4'd0) begin n_bad++; $display("FAIL m7_cnt got %0d want 0", res_cnt); end
        n_cmp++; if (res_fail !== 1'b1) begin n_bad++; $display("FAIL m7_fail got %b want 1", res_fail); end

        do_start(4'd6, 4'd2, 4'd3, pack(10'd1, 10'd1, 10'd0));
        wait_done(1, 10);
        n_cmp++; if (done_edge != 1) begin n_bad++; $display("FAIL dgt_done got %0d want 1", done_edge); end
        n_cmp++; if (res_fail !== 1'b1) begin n_bad++; $display("FAIL dgt_fail got %b want 1", res_fail); end
    endtask

    task automatic test_ignored_start;
        // alpha^5 = 0x20 in GF(2^6); root at k = 58 -> E59, loc 5.
        do_start(4'd6, 4'd2, 4'd1, pack(10'd1, 10'h020, 10'd0));
        repeat (10) @(posedge clk);
        @(negedge clk);
        m = 4'd8; t = 4'd4; degree = 4'd2; sigma = pack(10'd1, 10'd1, 10'd0); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(12, 100);
        n_cmp++;
        if (ev_edge.size() != 1) begin
            n_bad++; $display("FAIL ign_nloc got %0d want 1", ev_edge.size());
        end else begin
            n_cmp++; if (ev_edge[0] != 59) begin n_bad++; $display("FAIL ign_edge got %0d want 59", ev_edge[0]); end
            n_cmp++; if (ev_loc[0] !== 10'd5) begin n_bad++; $display("FAIL ign_loc got %0d want 5", ev_loc[0]); end
        end
        n_cmp++; if (done_edge != 64) begin n_bad++; $display("FAIL ign_done got %0d want 64", done_edge); end
        n_cmp++; if (res_cnt !== 4'd1) begin n_bad++; $display("FAIL ign_cnt got %0d want 1", res_cnt); end
        n_cmp++; if (res_fail !== 1'b0) begin n_bad++; $display("FAIL ign_fail got %b want 0", res_fail); end
        // Start held through the done cycle must not launch a scan.
        m = 4'd6; t = 4'd2; degree = 4'd1; sigma = pack(10'd1, 10'd1, 10'd0); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL done_start_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_scan;
        int ndone;
        do_start(4'd6, 4'd2, 4'd1, pack(10'd1, 10'd1, 10'd0));
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (err_cnt !== 4'd1) begin n_bad++; $display("FAIL pre_rst_cnt got %0d want 1", err_cnt); end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mrst_busy got %b want 0", busy); end
        n_cmp++; if (err_cnt !== 4'd0) begin n_bad++; $display("FAIL mrst_cnt got %0d want 0", err_cnt); end
        n_cmp++; if (loc_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_lv got %b want 0", loc_valid); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mrst_done got %b want 0", done); end
        n_cmp++; if (failure !== 1'b0) begin n_bad++; $display("FAIL mrst_fail got %b want 0", failure); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        ndone = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        n_cmp++; if (ndone != 0) begin n_bad++; $display("FAIL mrst_nodone got %0d want 0", ndone); end
    endtask

    task automatic test_after_reset;
        do_start(4'd6, 4'd2, 4'd1, pack(10'd1, 10'd1, 10'd0));
        wait_done(1, 100);
        n_cmp++; if (done_edge != 64) begin n_bad++; $display("FAIL post_done got %0d want 64", done_edge); end
        n_cmp++; if (res_cnt !== 4'd1) begin n_bad++; $display("FAIL post_cnt got %0d want 1", res_cnt); end
        n_cmp++; if (res_fail !== 1'b0) begin n_bad++; $display("FAIL post_fail got %b want 0", res_fail); end
    endtask

    initial begin
        test_reset();
        test_m6_single();
        test_m8_single();
        test_m10_double();
        test_degree_mismatch();
        test_early_exits();
        test_ignored_start();
        test_reset_mid_scan();
        test_after_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/chien_search.md
Name: chien_search

Overview:
- Consumer end of the error-locator interface. Takes sigma(x) and its degree, as produced by the Berlekamp-Massey stage, on a start pulse.
- Evaluates sigma at alpha^k for k = 0..n-1, with n = 2^m - 1 and one evaluation per clock.
- Emits one codeword error position for each root found.
- At the end of the scan, reports the root count and a failure flag to the correction stage.

Parameters:
- T_MAX, 4: maximum correctable errors; sigma holds T_MAX+1 coefficients.
- M_MAX, 10: maximum field width; width of each packed coefficient slot.

Ports:
- clk, input, 1: clock, rising edge.
- rstn, input, 1: reset, asynchronous, active-low.
- start, input, 1: single-cycle pulse that captures t, m, degree and sigma.
- t, input, 4: configured correction capability, 1..T_MAX.
- m, input, 4: field width; supported values are 6, 8 and 10.
- degree, input, 4: degree of sigma as reported by Berlekamp.
- sigma, input, (T_MAX+1)*M_MAX: coefficient j sits in bits [j*M_MAX +: M_MAX]; only the low m bits are used.
- busy, output, 1: high while a scan is in progress.
- loc_valid, output, 1: one-cycle pulse for each root found.
- loc, output, M_MAX: error position qualified by loc_valid.
- done, output, 1: one-cycle end-of-scan pulse.
- err_cnt, output, 4: number of roots found; valid from done until the next start.
- failure, output, 1: decode failure; valid from done until the next start.

Behaviour:
- Reset (rstn low, asynchronous) clears every output to 0 (busy, loc_valid, loc, done, err_cnt, failure), returns the FSM to IDLE and clears the internal registers.
- Primitive polynomials:
  - m=6: x^6+x+1
  - m=8: x^8+x^4+x^3+x^2+1
  - m=10: x^10+x^3+1
  - alpha is the root of the selected polynomial.
- FSM states: IDLE, SCAN, FIN.
- IDLE, start=1 at edge E0: capture inputs and clear err_cnt and failure. Then one of three cases:
  - m unsupported, or degree > t: go to FIN. done, failure=1 and err_cnt=0 appear after E1, with no scan.
  - degree = 0: go to FIN. done, err_cnt=0 and failure=0 appear after E1.
  - Otherwise: load r_j = sigma_j for j = 0..T_MAX, set k=0, go to SCAN, and raise busy after E0.
- SCAN, each cycle:
  - S = XOR of all r_j, computed combinationally on m bits.
  - If S == 0, at the next edge: loc_valid=1, loc = (k==0) ? 0 : n-k, and err_cnt += 1 (saturating at 15).
  - Every cycle, r_j <= r_j * alpha^j using a constant GF(2^m) multiplier selected by the captured m. Upper bits above m are forced to 0.
  - k increments each cycle. When k == n-1 the scan evaluates that last position and goes to FIN.
- Scan timing:
  - Position k is reported at edge E(k+1); the last report is at E(n).
  - Because loc = n-k, positions come out in descending order after position 0.
- FIN: at the next edge E(n+1), done=1 for one cycle, busy=0, and failure = (err_cnt != captured degree). Return to IDLE.
- Output holding:
  - err_cnt and failure hold until the next accepted start.
  - loc holds its last value and is only meaningful while loc_valid=1.
- start while busy=1, or in the done cycle, is ignored. The scan and its captured inputs are unaffected.
- loc_valid is never asserted in the same cycle as done.
- Total latency from the start edge to done is n+1 cycles (64, 256 or 1024).
- Reset mid-scan aborts immediately: no done pulse and all outputs at 0. Behaviour after reset is as from power-up.

Test Plan:
- m=6, t=2, degree=1, sigma=1+x -> a single loc_valid after E1 with loc=0; done after E64 with err_cnt=1, failure=0.
- m=8, t=4, degree=1, sigma=1+alpha^5·x -> a single loc_valid with loc=5, at edge E251 (k=250); done after E256, err_cnt=1, failure=0.
- m=10, t=4, degree=2, sigma=(1+alpha^3·x)(1+alpha^100·x), coefficients computed by the bench model -> loc=100 at E924, then loc=3 at E1021; done after E1024, err_cnt=2, failure=0.
- Degree mismatch and early exits:
  - m=6, degree=2, sigma=1+x -> done with err_cnt=1, failure=1.
  - degree=0 -> done after E1, err_cnt=0, failure=0.
  - m=7 -> done after E1, failure=1.
  - degree=3 with t=2 -> done after E1, failure=1.
- Robustness:
  - A second start pulse mid-scan is ignored; results match the first request exactly.
  - rstn pulsed low mid-scan -> all outputs 0 immediately and no done.
  - A fresh start after reset completes normally.
